// File: rtl/mpu_elementwise_seq.sv
// mpu_elementwise_seq
// Sequential element-wise ADD/SUB of two DIM x DIM signed matrices. LANES
// elements are computed per clock, so one operation takes NBEATS beats.
// Wrap and saturate modes are supported, and a sticky overflow flag reports
// whether any element's exact result fell outside the ELEM_W signed range.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and op are valid
//   in_ready   block can accept a new operation (IDLE)
//   op         00 ADD wrap, 01 SUB wrap, 10 ADD saturate, 11 SUB saturate
//   matrix_a   flattened matrix A, element (r,c) at [(r*DIM+c)*ELEM_W +: ELEM_W]
//   matrix_b   flattened matrix B, same layout
//   out_valid  result and overflow are valid (DONE)
//   out_ready  consumer accepts the result
//   result     flattened result matrix, same layout
//   overflow   at least one element overflowed during this operation
//   busy       high while an operation is in flight (CALC or DONE)
module mpu_elementwise_seq #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8,
    parameter int LANES  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic [ELEM_W*DIM*DIM-1:0] matrix_a,
    input  logic [ELEM_W*DIM*DIM-1:0] matrix_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELEM_W*DIM*DIM-1:0] result,
    output logic                      overflow,
    output logic                      busy
);

    localparam int NELEM  = DIM * DIM;
    localparam int NBEATS = (NELEM + LANES - 1) / LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    localparam logic [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
    localparam logic [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state;
    logic [BW-1:0]              beat;
    logic [ELEM_W*NELEM-1:0]    a_q;
    logic [ELEM_W*NELEM-1:0]    b_q;
    logic [1:0]                 op_q;

    int                         lane_idx   [LANES];
    logic signed [ELEM_W:0]     lane_exact [LANES];
    logic [ELEM_W-1:0]          lane_val   [LANES];
    logic [LANES-1:0]           lane_en;
    logic [LANES-1:0]           lane_ovf;

    // Exact signed add/sub at ELEM_W+1 bits; one extra bit is enough to
    // hold any sum or difference of two ELEM_W-bit signed values.
    function automatic logic signed [ELEM_W:0] exact_op(
        input logic [ELEM_W-1:0] a,
        input logic [ELEM_W-1:0] b,
        input logic              sub
    );
        logic signed [ELEM_W:0] ax;
        logic signed [ELEM_W:0] bx;
        ax = {a[ELEM_W-1], a};
        bx = {b[ELEM_W-1], b};
        return sub ? (ax - bx) : (ax + bx);
    endfunction

    // Shared lane array. Lane l of the current beat works on element
    // beat*LANES+l; lanes whose index runs past the matrix in the last
    // partial beat are disabled so they neither write nor flag overflow.
    // An element is out of range when the two top bits of its exact value
    // disagree; saturate modes then clamp toward the sign of the exact value.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l]   = int'(beat) * LANES + l;
            lane_en[l]    = 1'b0;
            lane_ovf[l]   = 1'b0;
            lane_exact[l] = '0;
            lane_val[l]   = '0;
            if (lane_idx[l] < NELEM) begin
                lane_en[l]    = 1'b1;
                lane_exact[l] = exact_op(a_q[lane_idx[l]*ELEM_W +: ELEM_W],
                                         b_q[lane_idx[l]*ELEM_W +: ELEM_W],
                                         op_q[0]);
                lane_ovf[l]   = lane_exact[l][ELEM_W] ^ lane_exact[l][ELEM_W-1];
                if (lane_ovf[l] && op_q[1]) begin
                    lane_val[l] = lane_exact[l][ELEM_W] ? SAT_MIN : SAT_MAX;
                end else begin
                    lane_val[l] = lane_exact[l][ELEM_W-1:0];
                end
            end
        end
    end

    // Control FSM with registered handshake outputs. IDLE latches the
    // operands so later input changes cannot disturb the operation, CALC
    // walks the beats writing finished elements into result, and DONE holds
    // result and overflow until the consumer takes them. result is not
    // cleared between operations; the next operation's beats overwrite it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= matrix_a;
                        b_q      <= matrix_b;
                        op_q     <= op;
                        overflow <= 1'b0;
                        beat     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_en[l]) begin
                            result[lane_idx[l]*ELEM_W +: ELEM_W] <= lane_val[l];
                        end
                    end
                    overflow <= overflow | (|lane_ovf);
                    if (beat == LAST_BEAT) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_elementwise_seq.sv
// tb_mpu_elementwise_seq
// Bench for mpu_elementwise_seq. Two instances are used: one with
// LANES=5 (five full beats) and one with LANES=4 (seven beats, the last one
// partial). A table of directed vectors with hand-computed expected matrices
// is run through them, followed by backpressure and mid-operation reset
// sequences.
module tb_mpu_elementwise_seq;

    localparam int DIM = 5;
    localparam int W   = 8;
    localparam int MW  = W * DIM * DIM;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [1:0]    op;
    logic [MW-1:0] matrix_a;
    logic [MW-1:0] matrix_b;
    logic          out_ready;
    bit            use4;

    logic          in_valid5, in_ready5, out_valid5, overflow5, busy5;
    logic          in_valid4, in_ready4, out_valid4, overflow4, busy4;
    logic [MW-1:0] result5, result4;

    logic          in_ready_s, out_valid_s, overflow_s, busy_s;
    logic [MW-1:0] result_s;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] exp;
        logic          exp_ovf;
        bit            use4;
        int            exp_lat;
    } vec_t;

    vec_t vecs[9];

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Route the shared stimulus to whichever instance is under test and
    // pick that instance's outputs for checking
    assign in_valid5   = in_valid & ~use4;
    assign in_valid4   = in_valid & use4;
    assign in_ready_s  = use4 ? in_ready4  : in_ready5;
    assign out_valid_s = use4 ? out_valid4 : out_valid5;
    assign overflow_s  = use4 ? overflow4  : overflow5;
    assign busy_s      = use4 ? busy4      : busy5;
    assign result_s    = use4 ? result4    : result5;

    mpu_elementwise_seq #(.DIM(DIM), .ELEM_W(W), .LANES(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .op(op), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .out_valid(out_valid5), .out_ready(out_ready), .result(result5),
        .overflow(overflow5), .busy(busy5)
    );

    mpu_elementwise_seq #(.DIM(DIM), .ELEM_W(W), .LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .op(op), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
        .overflow(overflow4), .busy(busy4)
    );

    function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
        logic [MW-1:0] m;
        for (int k = 0; k < DIM*DIM; k++) m[k*W +: W] = v;
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [MW-1:0] actual,
                               input logic [MW-1:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    endtask

    // Presents one operation and waits for out_valid. Called at posedge+1;
    // returns at posedge+1 of the edge where out_valid was first seen. The
    // operands are scrambled right after the accept edge so only latched
    // values can reach the result.
    task automatic applyStimulus(input vec_t v, input bit hold_ready, output int lat);
        use4      = v.use4;
        op        = v.op;
        matrix_a  = v.a;
        matrix_b  = v.b;
        out_ready = !hold_ready;
        checkOutput({v.name, " in_ready idle"}, MW'(in_ready_s), MW'(1'b1));
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        matrix_a  = ~v.a;
        matrix_b  = v.b ^ fill(8'h5A);
        op        = ~v.op;
        lat = 1;
        while (!out_valid_s && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full operation with out_ready held high in advance
    task automatic runVector(input int i);
        int lat;
        applyStimulus(vecs[i], 1'b0, lat);
        checkOutput({vecs[i].name, " latency"}, MW'(lat), MW'(vecs[i].exp_lat));
        checkOutput({vecs[i].name, " result"}, result_s, vecs[i].exp);
        checkOutput({vecs[i].name, " overflow"}, MW'(overflow_s), MW'(vecs[i].exp_ovf));
        checkOutput({vecs[i].name, " busy done"}, MW'(busy_s), MW'(1'b1));
        checkOutput({vecs[i].name, " in_ready done"}, MW'(in_ready_s), MW'(1'b0));
        @(posedge clk); #1;
        checkOutput({vecs[i].name, " out_valid one cycle"}, MW'(out_valid_s), MW'(1'b0));
        checkOutput({vecs[i].name, " in_ready after"}, MW'(in_ready_s), MW'(1'b1));
        checkOutput({vecs[i].name, " busy after"}, MW'(busy_s), MW'(1'b0));
    endtask

    initial begin
        int lat;
        int seen;

        // Directed vector table
        vecs[0] = '{"ramp sub wrap", 2'b01, '0, '0, '0, 1'b0, 1'b0, 6};
        for (int k = 0; k < 25; k++) begin
            vecs[0].a[k*W +: W]   = 8'(k + 1);
            vecs[0].b[k*W +: W]   = 8'(25 - k);
            vecs[0].exp[k*W +: W] = 8'(2*k - 24);
        end
        vecs[1] = '{"sub sat pos", 2'b11, fill(8'd100), fill(8'h9C), fill(8'h7F), 1'b1, 1'b0, 6};
        vecs[2] = '{"sub wrap pos", 2'b01, fill(8'd100), fill(8'h9C), fill(8'hC8), 1'b1, 1'b0, 6};
        vecs[3] = '{"add sat neg", 2'b10, fill(8'h80), fill(8'hFF), fill(8'h80), 1'b1, 1'b0, 6};
        vecs[4] = '{"add wrap neg", 2'b00, fill(8'h80), fill(8'hFF), fill(8'h7F), 1'b1, 1'b0, 6};
        vecs[5] = '{"sub sat neg", 2'b11, fill(8'h80), fill(8'h01), fill(8'h80), 1'b1, 1'b0, 6};
        vecs[6] = '{"add sat edge max", 2'b10, fill(8'd50), fill(8'd77), fill(8'h7F), 1'b0, 1'b0, 6};
        vecs[7] = '{"sub wrap edge min", 2'b01, fill(8'h9C), fill(8'd28), fill(8'h80), 1'b0, 1'b0, 6};
        vecs[8] = '{"partial beat", 2'b00, '0, fill(8'd1), '0, 1'b0, 1'b1, 8};
        for (int k = 0; k < 25; k++) begin
            vecs[8].a[k*W +: W]   = 8'(k);
            vecs[8].exp[k*W +: W] = 8'(k + 1);
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        matrix_a  = '0;
        matrix_b  = '0;
        out_ready = 1'b0;
        use4      = 1'b0;

        // Reset state
        @(posedge clk); #1;
        checkOutput("reset in_ready", MW'(in_ready5), MW'(1'b1));
        checkOutput("reset out_valid", MW'(out_valid5), MW'(1'b0));
        checkOutput("reset busy", MW'(busy5), MW'(1'b0));
        checkOutput("reset result", result5, '0);
        checkOutput("reset overflow", MW'(overflow5), MW'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) runVector(i);

        // Backpressure: DONE held for four cycles with in_valid pulses
        applyStimulus(vecs[1], 1'b1, lat);
        checkOutput("bp latency", MW'(lat), MW'(6));
        for (int c = 0; c < 4; c++) begin
            in_valid = c[0];
            matrix_a = fill(8'(c));
            matrix_b = fill(8'(c + 3));
            @(posedge clk); #1;
            checkOutput("bp out_valid held", MW'(out_valid_s), MW'(1'b1));
            checkOutput("bp result held", result_s, vecs[1].exp);
            checkOutput("bp overflow held", MW'(overflow_s), MW'(1'b1));
            checkOutput("bp in_ready low", MW'(in_ready_s), MW'(1'b0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp release out_valid", MW'(out_valid_s), MW'(1'b0));
        checkOutput("bp release in_ready", MW'(in_ready_s), MW'(1'b1));
        checkOutput("bp result kept in idle", result_s, vecs[1].exp);

        // Reset in the middle of CALC
        use4      = 1'b0;
        op        = vecs[0].op;
        matrix_a  = vecs[0].a;
        matrix_b  = vecs[0].b;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("abort in_ready", MW'(in_ready5), MW'(1'b1));
        checkOutput("abort out_valid", MW'(out_valid5), MW'(1'b0));
        checkOutput("abort busy", MW'(busy5), MW'(1'b0));
        checkOutput("abort result", result5, '0);
        checkOutput("abort overflow", MW'(overflow5), MW'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid5) seen = 1;
        end
        checkOutput("abort no out_valid", MW'(seen), MW'(0));
        runVector(0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
